font_rom_arbiter: RTL and testbench

- Shares the single synchronous font ROM between two text-rendering requesters.
  - Port 0: clock-digit painter.
  - Port 1: state/status-line painter.
- Arbitrates one ROM read per clock, drives the ROM address, and routes returned glyph rows back to the issuing requester with fixed latency.
- Sits between the text painters and the font ROM inside the VGA painter top level, in the pixel clock domain.

---
 rtl/vga_text_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 51 +++++
 rtl/font_rom_arbiter.sv | 114 +++++++++++
 tb/tb_font_rom_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text painters and the font ROM.
package vga_text_pkg;

   localparam int unsigned FONT_ADDR_W  = 11;  // {char code[6:0], row[3:0]}
   localparam int unsigned FONT_DATA_W  = 8;
   localparam int unsigned FONT_ROM_LAT = 1;

   // Requester indices as seen by the font ROM arbiter
   localparam logic PORT_DIGITS = 1'b0;
   localparam logic PORT_STATUS = 1'b1;

   // Travels alongside each issued ROM read so the returned row reaches its requester
   typedef struct packed {
      logic valid;
      logic port;
   } font_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: round-robin on conflicts (RR_EN=1) or fixed priority to port 0.
module rr_arbiter2
   import vga_text_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic last_q, last_d;

   // Grant decode and next value of the last-granted pointer
   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (req0 && req1) begin
         // On a conflict the port that was not served last wins
         if (RR_EN && (last_q == PORT_DIGITS)) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
      if (RR_EN) begin
         if (gnt0) begin
            last_d = PORT_DIGITS;
         end else if (gnt1) begin
            last_d = PORT_STATUS;
         end
      end
   end

   // Pointer starts at port 1 so port 0 wins the first conflict after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= PORT_STATUS;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between the clock-digit and status-line painters.
// One read issued per clock; returned rows are routed back by a tag pipeline.
module font_rom_arbiter
   import vga_text_pkg::*;
#(
   parameter int unsigned ADDR_W  = FONT_ADDR_W,
   parameter int unsigned DATA_W  = FONT_DATA_W,
   parameter int unsigned ROM_LAT = FONT_ROM_LAT,  // 1..3
   parameter bit          RR_EN   = 1'b1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [CNT_W-1:0]  conflict_cnt
);

   // One stage for the rom_addr register plus ROM_LAT stages inside the ROM
   localparam int unsigned PIPE_D = ROM_LAT + 1;

   logic [ADDR_W-1:0] rom_addr_q;
   logic              rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic [CNT_W-1:0]  conflict_cnt_q;
   font_tag_t         tag_q [PIPE_D];
   font_tag_t         new_tag;
   font_tag_t         out_tag;

   rr_arbiter2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   // Tag for the read issued this cycle and the tag whose data is on rom_data now
   always_comb begin
      new_tag       = '0;
      new_tag.valid = gnt0 | gnt1;
      new_tag.port  = gnt1 ? PORT_STATUS : PORT_DIGITS;
      out_tag       = tag_q[PIPE_D-1];
   end

   // Issue: latch the granted address and push its tag into the pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr_q <= '0;
         for (int i = 0; i < PIPE_D; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (gnt0) begin
            rom_addr_q <= addr0;
         end else if (gnt1) begin
            rom_addr_q <= addr1;
         end
         tag_q[0] <= new_tag;
         for (int i = 1; i < PIPE_D; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Return: capture ROM data for the tagged port; the other port keeps its last row
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= out_tag.valid && (out_tag.port == PORT_DIGITS);
         rvalid1_q <= out_tag.valid && (out_tag.port == PORT_STATUS);
         if (out_tag.valid && (out_tag.port == PORT_DIGITS)) begin
            rdata0_q <= rom_data;
         end
         if (out_tag.valid && (out_tag.port == PORT_STATUS)) begin
            rdata1_q <= rom_data;
         end
      end
   end

   // Saturating count of cycles where both painters contend
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt_q <= '0;
      end else if (req0 && req1 && (conflict_cnt_q != {CNT_W{1'b1}})) begin
         conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign rvalid0      = rvalid0_q;
   assign rvalid1      = rvalid1_q;
   assign rdata0       = rdata0_q;
   assign rdata1       = rdata1_q;
   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench: three instances (round-robin, fixed priority, 4-bit counter) share stimulus.
module tb_font_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [10:0] addr0, addr1;

   logic        rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1;
   logic [7:0]  rr_rdata0, rr_rdata1, rr_rom_data;
   logic [10:0] rr_rom_addr;
   logic [15:0] rr_cnt;

   logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1;
   logic [7:0]  fp_rdata0, fp_rdata1, fp_rom_data;
   logic [10:0] fp_rom_addr;
   logic [15:0] fp_cnt;

   logic        c4_gnt0, c4_gnt1, c4_rvalid0, c4_rvalid1;
   logic [7:0]  c4_rdata0, c4_rdata1, c4_rom_data;
   logic [10:0] c4_rom_addr;
   logic [3:0]  c4_cnt;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        m_last;
   logic [10:0] m_rom_addr;
   logic [15:0] m_cnt;
   logic [3:0]  m_cnt4;
   logic [7:0]  m_rd0, m_rd1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rom_fn(input logic [10:0] a);
      if (a == 11'h305) return 8'h3C;
      return (a[7:0] * 8'd7) ^ {5'd0, a[10:8]};
   endfunction

   // Font ROM models, one read latency each
   always @(posedge clk) begin
      rr_rom_data <= rom_fn(rr_rom_addr);
      fp_rom_data <= rom_fn(fp_rom_addr);
      c4_rom_data <= rom_fn(c4_rom_addr);
   end

   font_rom_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(rr_gnt0), .rvalid0(rr_rvalid0), .rdata0(rr_rdata0),
      .req1(req1), .addr1(addr1), .gnt1(rr_gnt1), .rvalid1(rr_rvalid1), .rdata1(rr_rdata1),
      .rom_addr(rr_rom_addr), .rom_data(rr_rom_data), .conflict_cnt(rr_cnt)
   );

   font_rom_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(fp_gnt0), .rvalid0(fp_rvalid0), .rdata0(fp_rdata0),
      .req1(req1), .addr1(addr1), .gnt1(fp_gnt1), .rvalid1(fp_rvalid1), .rdata1(fp_rdata1),
      .rom_addr(fp_rom_addr), .rom_data(fp_rom_data), .conflict_cnt(fp_cnt)
   );

   font_rom_arbiter #(.CNT_W(4)) dut_c4 (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(c4_gnt0), .rvalid0(c4_rvalid0), .rdata0(c4_rdata0),
      .req1(req1), .addr1(addr1), .gnt1(c4_gnt1), .rvalid1(c4_rvalid1), .rdata1(c4_rdata1),
      .rom_addr(c4_rom_addr), .rom_data(c4_rom_data), .conflict_cnt(c4_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: check outputs mid-cycle, advance the model, then step past the edge
   task automatic tick();
      logic g0, g1, f0, f1;
      exp_t e;
      @(negedge clk);
      if (req0 && req1) begin
         g0 = m_last;
         g1 = !m_last;
      end else begin
         g0 = req0;
         g1 = req1;
      end
      f0 = req0;
      f1 = req1 && !req0;
      if (!reset) begin
         check("rr_gnt0", rr_gnt0, g0);
         check("rr_gnt1", rr_gnt1, g1);
         check("fp_gnt0", fp_gnt0, f0);
         check("fp_gnt1", fp_gnt1, f1);
      end
      check("rom_addr", rr_rom_addr, m_rom_addr);
      check("conflict_cnt", rr_cnt, m_cnt);
      check("conflict_cnt4", c4_cnt, m_cnt4);
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
         e = q0.pop_front();
         check("rvalid0", rr_rvalid0, 1);
         check("rdata0", rr_rdata0, e.data);
         m_rd0 = e.data;
      end else begin
         check("rvalid0_idle", rr_rvalid0, 0);
         check("rdata0_hold", rr_rdata0, m_rd0);
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
         e = q1.pop_front();
         check("rvalid1", rr_rvalid1, 1);
         check("rdata1", rr_rdata1, e.data);
         m_rd1 = e.data;
      end else begin
         check("rvalid1_idle", rr_rvalid1, 0);
         check("rdata1_hold", rr_rdata1, m_rd1);
      end
      if (reset) begin
         m_last = 1'b1;
         m_rom_addr = '0;
         m_cnt = '0;
         m_cnt4 = '0;
         m_rd0 = '0;
         m_rd1 = '0;
         q0.delete();
         q1.delete();
      end else begin
         if (g0) begin
            e.cyc = cyc + 3;
            e.data = rom_fn(addr0);
            q0.push_back(e);
            m_rom_addr = addr0;
            m_last = 1'b0;
         end else if (g1) begin
            e.cyc = cyc + 3;
            e.data = rom_fn(addr1);
            q1.push_back(e);
            m_rom_addr = addr1;
            m_last = 1'b1;
         end
         if (req0 && req1) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      addr0 = '0;
      addr1 = '0;
      m_last = 1'b1;
      m_rom_addr = '0;
      m_cnt = '0;
      m_cnt4 = '0;
      m_rd0 = '0;
      m_rd1 = '0;
      tick();
      tick();
      reset = 1'b0;

      // Single read from port 0
      req0 = 1'b1;
      addr0 = 11'h305;
      tick();
      req0 = 1'b0;
      repeat (5) tick();

      // Both ports contending for six cycles
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req0 = 1'b1;
         req1 = 1'b1;
         addr0 = 11'h010 + 11'(i);
         addr1 = 11'h200 + 11'(i);
         tick();
      end
      check("conflict_six", rr_cnt, 16'd6);
      req0 = 1'b0;
      addr1 = 11'h206;
      tick();
      req1 = 1'b0;
      repeat (4) tick();

      // Back-to-back reads on port 0
      for (int i = 0; i < 16; i++) begin
         req0 = 1'b1;
         addr0 = 11'h100 + 11'(i);
         tick();
      end
      req0 = 1'b0;
      repeat (5) tick();

      // Reset while two reads are in flight
      req0 = 1'b1;
      addr0 = 11'h050;
      tick();
      req0 = 1'b0;
      req1 = 1'b1;
      addr1 = 11'h060;
      tick();
      req1 = 1'b0;
      do_reset();
      repeat (4) tick();
      req0 = 1'b1;
      req1 = 1'b1;
      addr0 = 11'h070;
      addr1 = 11'h270;
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (4) tick();

      // Reset coinciding with a request: the request is not issued
      req0 = 1'b1;
      addr0 = 11'h0AA;
      do_reset();
      req0 = 1'b0;
      repeat (4) tick();

      // Counter saturation on the 4-bit instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         req0 = 1'b1;
         req1 = 1'b1;
         addr0 = 11'h020 + 11'(i);
         addr1 = 11'h320 + 11'(i);
         tick();
      end
      check("cnt4_saturated", c4_cnt, 4'hF);
      check("cnt16_twenty", rr_cnt, 16'd20);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (5) tick();

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
